// File: rtl/moving_window_integrator.sv
// Moving-window integrator: running mean of the last 2**WINDOW_LOG2 accepted samples.
// Optional macro MWI_FILL_GATE_EN suppresses out_valid until the window has filled.
module moving_window_integrator #(
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_LOG2 = 5   // must be >= 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] xin,
  output logic signed [DATA_WIDTH-1:0] yout,
  output logic                         out_valid,
  output logic                         full
);

  localparam int N  = 1 << WINDOW_LOG2;
  localparam int AW = DATA_WIDTH + WINDOW_LOG2;
  localparam logic [WINDOW_LOG2:0] FILL_MAX = (WINDOW_LOG2 + 1)'(N);

  logic signed [DATA_WIDTH-1:0] r_mem [N];
  logic signed [DATA_WIDTH-1:0] r_rd_data;
  logic                         r_written [N];
  logic [WINDOW_LOG2-1:0]       r_ptr;
  logic [WINDOW_LOG2:0]         r_fill;
  logic signed [AW-1:0]         r_acc;

  logic                         w_accept;
  logic signed [DATA_WIDTH-1:0] w_oldest;
  logic [WINDOW_LOG2-1:0]       w_ptr_next;
  logic [WINDOW_LOG2-1:0]       w_rd_addr;
  logic [WINDOW_LOG2:0]         w_fill_next;
  logic signed [AW-1:0]         w_acc_next;
  logic signed [AW-1:0]         w_acc_shift;

  assign w_accept    = en & ~rst;
  assign w_ptr_next  = r_ptr + 1'b1;
  // Entries not written since reset count as zero, so the RAM itself needs no clear.
  assign w_oldest    = r_written[r_ptr] ? r_rd_data : '0;
  assign w_acc_next  = r_acc + AW'(xin) - AW'(w_oldest);
  assign w_acc_shift = w_acc_next >>> WINDOW_LOG2;
  assign w_fill_next = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
  // Prefetch the entry the pointer will sit on next, so the oldest sample is ready on accept.
  assign w_rd_addr   = w_accept ? w_ptr_next : r_ptr;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_ptr] <= xin;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_written
      always_ff @(posedge clk) begin
        if (rst) begin
          r_written[gi] <= 1'b0;
        end else if (w_accept && (r_ptr == WINDOW_LOG2'(gi))) begin
          r_written[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_ptr     <= '0;
      r_fill    <= '0;
      yout      <= '0;
      out_valid <= 1'b0;
      full      <= 1'b0;
    end else if (w_accept) begin
      r_acc  <= w_acc_next;
      r_ptr  <= w_ptr_next;
      r_fill <= w_fill_next;
      yout   <= w_acc_shift[DATA_WIDTH-1:0];
      full   <= (w_fill_next == FILL_MAX);
`ifdef MWI_FILL_GATE_EN
      out_valid <= (w_fill_next == FILL_MAX);
`else
      out_valid <= 1'b1;
`endif
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_window_integrator.sv
// Self-checking bench for moving_window_integrator (N=32, DATA_WIDTH=16),
// checked against a queue-based windowed-mean model; honours MWI_FILL_GATE_EN.
module tb_moving_window_integrator;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic signed [15:0] xin;
  logic signed [15:0] yout;
  logic               out_valid;
  logic               full;

  int tests = 0;
  int fails = 0;

  int          win_q[$];
  int          fill_cnt;
  longint      exp_y;
  logic        exp_v;

  moving_window_integrator #(.DATA_WIDTH(16), .WINDOW_LOG2(5)) dut (
    .clk(clk), .rst(rst), .en(en), .xin(xin),
    .yout(yout), .out_valid(out_valid), .full(full)
  );

  always #5 clk = ~clk;

  function automatic longint floor_div32(input longint s);
    longint q;
    q = s / 32;
    if ((s < 0) && (s % 32 != 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint window_mean();
    longint s = 0;
    foreach (win_q[i]) s += win_q[i];
    return floor_div32(s);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock of stimulus, then update the model and compare all outputs.
  task automatic cyc(input logic r, input logic e, input int x);
    @(negedge clk);
    rst = r;
    en  = e;
    xin = 16'(x);
    @(posedge clk);
    #1;
    if (r) begin
      win_q.delete();
      fill_cnt = 0;
      exp_y    = 0;
      exp_v    = 1'b0;
    end else if (e) begin
      win_q.push_back(x);
      if (win_q.size() > 32) void'(win_q.pop_front());
      if (fill_cnt < 32) fill_cnt++;
      exp_y = window_mean();
`ifdef MWI_FILL_GATE_EN
      exp_v = (fill_cnt == 32);
`else
      exp_v = 1'b1;
`endif
    end else begin
      exp_v = 1'b0;
    end
    $display("[TB] t=%0t rst=%0b en=%0b xin=%0d yout=%0d valid=%0b full=%0b", $time, r, e, x, yout, out_valid, full);
    chk("yout", 64'(yout), 64'(exp_y));
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    chk("full", 64'(full), 64'(fill_cnt == 32));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; xin = '0;
    fill_cnt = 0; exp_y = 0; exp_v = 1'b0;
    cyc(1, 0, 0);
    cyc(1, 1, 1234);
    chk("reset_yout", 64'(yout), 64'sd0);
    chk("reset_full", 64'(full), 64'sd0);

    // Ramp-up with a constant 64: yout = 2k after the k-th sample.
    for (int k = 1; k <= 32; k++) begin
      cyc(0, 1, 64);
      chk("ramp_2k", 64'(yout), 64'(2 * k));
    end
    chk("ramp_full", 64'(full), 64'sd1);
    for (int k = 0; k < 10; k++) cyc(0, 1, 64);
    chk("steady_64", 64'(yout), 64'sd64);

    // Decay through a full pointer wrap.
    for (int k = 1; k <= 32; k++) begin
      cyc(0, 1, 0);
      chk("decay", 64'(yout), 64'(64 - 2 * k));
    end

    // Extremes.
    for (int k = 0; k < 32; k++) cyc(0, 1, 32767);
    chk("max_pos", 64'(yout), 64'sd32767);
    for (int k = 0; k < 32; k++) cyc(0, 1, -32768);
    chk("max_neg", 64'(yout), -64'sd32768);

    // Enable gaps after a reset: yout held, no valid during idle.
    cyc(1, 0, 0);
    cyc(0, 1, 100);
    chk("gap_first", 64'(yout), 64'sd3);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 999);
      chk("gap_hold", 64'(yout), 64'sd3);
    end
    cyc(0, 1, 200);
    chk("gap_second", 64'(yout), 64'sd9);

    // Reset mid-window, asserted together with en so xin is discarded.
    for (int k = 0; k < 10; k++) cyc(0, 1, 320);
    cyc(1, 1, 5000);
    chk("midrst_yout", 64'(yout), 64'sd0);
    chk("midrst_valid", 64'(out_valid), 64'sd0);
    cyc(0, 1, 32);
    chk("post_rst_yout", 64'(yout), 64'sd1);
    chk("post_rst_full", 64'(full), 64'sd0);

    // Random signed stream with random enable.
    for (int k = 0; k < 500; k++) begin
      cyc(0, ($urandom % 4) != 0, int'($signed(16'($urandom))));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/moving_window_integrator.md
MOVING_WINDOW_INTEGRATOR -- requirements
Module: moving_window_integrator

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 16, sample width of xin and yout.
REQ-002 SHALL provide parameter WINDOW_LOG2, default 5, log2 of window length N (N = 2**WINDOW_LOG2 = 32 samples).
REQ-003 SHALL provide port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port en  input  1  sample strobe; xin is consumed on any rising clk edge where en=1 and rst=0.
REQ-006 SHALL provide port xin  input  DATA_WIDTH signed  input sample, the squared-derivative stream taken from the upstream delay line.
REQ-007 SHALL provide port yout  output  DATA_WIDTH signed  windowed mean of the last N accepted samples.
REQ-008 SHALL provide port out_valid  output  1  one-cycle pulse marking a new yout.
REQ-009 SHALL provide port full  output  1  high once N samples have been accepted since reset.

Function
REQ-010 SHALL hold an N-entry circular sample buffer, a write pointer (WINDOW_LOG2 bits), a fill counter saturating at N, and a signed accumulator of DATA_WIDTH+WINDOW_LOG2 bits.
REQ-011 SHALL, on an accepted sample, in one edge: read the oldest entry at the write pointer, write xin there, advance the pointer modulo N (N-1 -> 0), and update acc <= acc + xin - oldest.
REQ-012 SHALL treat buffer entries not yet written since reset as 0, so the partial-window sum equals the sum of the samples received so far.
REQ-013 SHALL drive yout registered as the new acc arithmetically shifted right by WINDOW_LOG2 (floor toward minus infinity), truncated to DATA_WIDTH; the accumulator width guarantees no overflow.
REQ-014 SHALL have latency 1: yout and out_valid update on the same edge that accepts xin.
REQ-015 SHALL pulse out_valid high for exactly one cycle per accepted sample, subject to REQ-022/023.
REQ-016 SHALL hold yout, acc, buffer, pointer and fill counter unchanged while en=0.
REQ-017 SHALL increment the fill counter per accepted sample until N; full SHALL rise on the edge accepting the N-th sample and remain high until reset.
REQ-018 SHALL, when rst and en are both high on the same edge, reset and discard xin.

Reset
REQ-019 SHALL, on rst=1 at a rising edge, set yout=0, out_valid=0, full=0, acc=0, pointer=0, fill counter=0, and all buffer entries to 0.
REQ-020 SHALL accept reset mid-window with no residual contribution from pre-reset samples.
REQ-021 SHALL accept a sample on the first edge after rst is deasserted.

Configuration
REQ-022 SHALL, with macro MWI_FILL_GATE_EN defined, assert out_valid only for accepted samples for which full is high after that edge (N-th sample onward); yout still updates on every accepted sample.
REQ-023 SHALL, without MWI_FILL_GATE_EN, pulse out_valid for every accepted sample from the first one.

Verification (N=32, DATA_WIDTH=16)
REQ-024 SHALL verify ramp-up: 32 consecutive samples of 64 -> yout=2k after the k-th sample, yout=64 and full=1 after the 32nd; 10 more samples of 64 -> yout stays 64.
REQ-025 SHALL verify decay/wrap: after REQ-024, 32 samples of 0 -> yout drops by 2 per sample, reaching 0 on the 32nd; pointer wraps cleanly.
REQ-026 SHALL verify extremes: 32 samples of 32767 -> yout=32767; then 32 samples of -32768 -> yout=-32768; no wrap-around glitch.
REQ-027 SHALL verify en gaps: samples 100,200 with 5 idle cycles between -> yout 3 then 9 (floor of 300/32), held during the gap; out_valid high only on the 2 accepting edges.
REQ-028 SHALL verify reset mid-operation: 10 samples of 320, then rst for 1 cycle, then one sample of 32 -> after reset all outputs 0, then yout=1 and full=0.
REQ-029 SHALL verify random stream: 500 random signed samples with random en -> yout matches a reference model of floor(sum of last 32 accepted / 32) every accepted sample, in both macro builds with out_valid gating per REQ-022/023.
